// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and a
// constant-evaluable ceiling log2 used to size counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int unsigned OVERSAMPLE = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Registered-read FIFO port between the TX byte FIFO (slave) and the
// transmitter that drains it (master).
interface uart_tx_fifo_drain_if #(
  parameter int unsigned DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: tick is high for one clk every CLK_DIV clk;
// clr restarts the count so the following tick lands CLK_DIV-1 clk later.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from a registered-read FIFO and sends
// start, DBIT data bits LSB-first, optional parity and a stop period.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned CLK_DIV    = 27,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  uart_tx_fifo_drain_if.master  fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int unsigned   BW       = clog2(DBIT);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);
  localparam logic [4:0]    OS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);

  state_e          state_q, state_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [BW-1:0]   n_q, n_d;
  logic [4:0]      s_q, s_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            tick;
  logic            rd;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == LOAD),
    .tick  (tick)
  );

  // Gated by reset so no pop can be issued while the FSM is held in reset.
  assign rd           = reset && (state_q == IDLE) && tx_en && !fifo.fifo_empty;
  assign fifo.fifo_rd = rd;
  assign tx_busy      = (state_q != IDLE);
  assign tx           = tx_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    n_d          = n_q;
    s_d          = s_q;
    par_d        = par_q;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: if (rd) state_d = LOAD;
      LOAD: begin
        shift_d = fifo.fifo_r_data;
        par_d   = (^fifo.fifo_r_data) ^ PARITY_ODD;
        n_d     = '0;
        s_d     = '0;
        state_d = START;
      end
      START: if (tick) begin
        if (s_q == OS_LAST) begin
          s_d     = '0;
          n_d     = '0;
          state_d = DATA;
        end else s_d = s_q + 5'd1;
      end
      DATA: if (tick) begin
        if (s_q == OS_LAST) begin
          s_d     = '0;
          shift_d = shift_q >> 1;
          if (n_q == LAST_BIT) begin
            n_d     = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else n_d = n_q + BW'(1);
        end else s_d = s_q + 5'd1;
      end
      PARITY: if (tick) begin
        if (s_q == OS_LAST) begin
          s_d     = '0;
          state_d = STOP;
        end else s_d = s_q + 5'd1;
      end
      STOP: if (tick) begin
        if (s_q == SB_LAST) begin
          s_d          = '0;
          tx_done_tick = 1'b1;
          state_d      = IDLE;
        end else s_d = s_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it changes together with it.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      n_q     <= '0;
      s_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      n_q     <= n_d;
      s_q     <= s_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: three instances at CLK_DIV = 4
// (no parity, even parity, odd parity) each fed by a small FIFO model.
module tb_uart_tx_fifo_drain;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nb;
    logic [11:0] frame;
    bit          b2b;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] tx_en = 3'b111;
  logic [2:0] tx_w, rd_w, busy_w, done_w;

  logic [7:0] mem   [3][16];
  logic [3:0] wp    [3] = '{default: '0};
  logic [3:0] rp    [3] = '{default: '0};
  logic [7:0] rdata [3] = '{default: '0};

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_drain_if #(.DBIT(8)) f0 ();
  uart_tx_fifo_drain_if #(.DBIT(8)) f1 ();
  uart_tx_fifo_drain_if #(.DBIT(8)) f2 ();

  assign f0.fifo_empty  = (rp[0] == wp[0]);
  assign f1.fifo_empty  = (rp[1] == wp[1]);
  assign f2.fifo_empty  = (rp[2] == wp[2]);
  assign f0.fifo_r_data = rdata[0];
  assign f1.fifo_r_data = rdata[1];
  assign f2.fifo_r_data = rdata[2];
  assign rd_w[0] = f0.fifo_rd;
  assign rd_w[1] = f1.fifo_rd;
  assign rd_w[2] = f2.fifo_rd;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) begin
        rdata[i] <= mem[i][rp[i]];
        rp[i]    <= rp[i] + 4'd1;
      end
    end
  end

  uart_tx_fifo_drain #(.CLK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en[0]), .fifo(f0),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
  );
  uart_tx_fifo_drain #(.CLK_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en[1]), .fifo(f1),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
  );
  uart_tx_fifo_drain #(.CLK_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .reset(reset), .tx_en(tx_en[2]), .fifo(f2),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [7:0] d);
    mem[s][wp[s]] = d;
    wp[s] = wp[s] + 4'd1;
  endtask

  task automatic wait_rd(input int s, output int c0);
    bit found;
    found = 1'b0;
    c0    = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (i > 0) tick();
      else #1;
      if (rd_w[s]) begin
        found = 1'b1;
        c0    = cyc;
      end
    end
    chk("rd_seen", 32'(found), 32'd1);
  endtask

  // Called at the slot where fifo_rd is high; ends at the first idle slot.
  task automatic run_frame(input int s, input int nb, input logic [11:0] fr, input int drop_at);
    for (int o = 1; o <= nb * 64 + 2; o++) begin
      tick();
      if (o == 1) begin
        chk("rd_pulse_1cyc", 32'(rd_w[s]), 32'd0);
        chk("tx_before_start", 32'(tx_w[s]), 32'd1);
      end
      if (o == 2)  chk("tx_start_latency", 32'(tx_w[s]), 32'd0);
      if (o == 65) chk("tx_start_end", 32'(tx_w[s]), 32'd0);
      if (o >= 2 && (o - 2) % 64 == 32)
        chk($sformatf("bit%0d", (o - 2) / 64), 32'(tx_w[s]), 32'(fr[(o - 2) / 64]));
      if (o == nb * 64) chk("done_early", 32'(done_w[s]), 32'd0);
      if (o == nb * 64 + 1) begin
        chk("done_pulse", 32'(done_w[s]), 32'd1);
        chk("busy_in_stop", 32'(busy_w[s]), 32'd1);
      end
      if (o == nb * 64 + 2) begin
        chk("idle_busy", 32'(busy_w[s]), 32'd0);
        chk("idle_tx", 32'(tx_w[s]), 32'd1);
      end
      if (o == drop_at) tx_en[s] = 1'b0;
    end
  endtask

  vec_t vt[5];
  int   c0, prev_c0, rel_cyc, seen;

  initial begin
    vt[0] = '{0, 8'hA5, 10, 12'b00_1_10100101_0, 1'b0};
    vt[1] = '{0, 8'h00, 10, 12'b00_1_00000000_0, 1'b0};
    vt[2] = '{0, 8'hFF, 10, 12'b00_1_11111111_0, 1'b1};
    vt[3] = '{1, 8'h07, 11, 12'b0_1_1_00000111_0, 1'b0};
    vt[4] = '{2, 8'h07, 11, 12'b0_1_0_00000111_0, 1'b0};
    prev_c0 = 0;

    // Reset held with a byte waiting and tx_en high.
    push(0, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_tx", 32'(tx_w[0]), 32'd1);
      chk("rst_rd", 32'(rd_w[0]), 32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_done", 32'(done_w[0]), 32'd0);
    end
    reset   = 1'b1;
    rel_cyc = cyc;
    wait_rd(0, c0);
    chk("rd_after_release", 32'(c0), 32'(rel_cyc));
    run_frame(0, 10, 12'b00_1_00111100_0, 0);

    for (int i = 0; i < 5; i++) begin
      if (!vt[i].b2b) push(vt[i].sel, vt[i].data);
      if (i < 4 && vt[i + 1].b2b) push(vt[i + 1].sel, vt[i + 1].data);
      wait_rd(vt[i].sel, c0);
      if (vt[i].b2b) chk("b2b_gap", 32'(c0 - prev_c0), 32'd642);
      run_frame(vt[i].sel, vt[i].nb, vt[i].frame, 0);
      prev_c0 = c0;
    end

    // Reset during data bit 3, then a fresh frame after release.
    push(0, 8'h5A);
    wait_rd(0, c0);
    for (int o = 1; o <= 2 + 64 * 4 + 10; o++) tick();
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx_w[0]), 32'd1);
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    push(0, 8'hC3);
    tick();
    chk("midrst_rd", 32'(rd_w[0]), 32'd0);
    tick();
    reset   = 1'b1;
    rel_cyc = cyc;
    wait_rd(0, c0);
    chk("rd_after_midrst", 32'(c0), 32'(rel_cyc));
    run_frame(0, 10, 12'b00_1_11000011_0, 0);

    // tx_en low blocks fetches; dropping it mid-frame lets the frame finish.
    tx_en[0] = 1'b0;
    push(0, 8'h81);
    push(0, 8'h42);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rd_w[0]) seen++;
    end
    chk("no_rd_disabled", 32'(seen), 32'd0);
    tx_en[0] = 1'b1;
    wait_rd(0, c0);
    run_frame(0, 10, 12'b00_1_10000001_0, 2 + 64 * 4);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rd_w[0]) seen++;
    end
    chk("no_rd_after_drop", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
